// File: rtl/ir_beacon_voter.sv
// Votes across consecutive IR detector decisions and publishes a debounced
// beacon identity, with lock loss after a window without valid results.
module ir_beacon_voter #(
  parameter int unsigned CONFIRM_N      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        done,
  input  logic [2:0]  decision,
  input  logic [19:0] clk_count,
  output logic [2:0]  beacon_id,
  output logic        beacon_valid,
  output logic        beacon_change,
  output logic        beacon_lost,
  output logic [19:0] last_period
);

  localparam int unsigned CODE_W   = 3;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned TIMER_W  = 21;
  localparam int unsigned PERIOD_W = 20;

  localparam logic [TIMER_W-1:0] TIMEOUT    = TIMER_W'(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMEOUT_M1 = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CONFIRM    = CNT_W'(CONFIRM_N);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CAND   = 2'd1,
    S_LOCKED = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CODE_W-1:0]    cand_q, cand_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [CODE_W-1:0]    id_q, id_d;
  logic                 valid_q, valid_d;
  logic                 change_q, change_d;
  logic                 lost_q, lost_d;
  logic [PERIOD_W-1:0]  period_q, period_d;

  logic                 valid_c;
  logic                 timeout_c;
  logic [CNT_W-1:0]     cnt_inc_c;

  // Qualify the strobe and detect the cycle in which the timer would expire.
  always_comb begin
    valid_c   = done && (decision >= CODE_W'(1)) && (decision <= CODE_W'(4));
    timeout_c = !valid_c && (timer_q == TIMEOUT_M1);
    cnt_inc_c = cnt_q + CNT_W'(1);
  end

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cand_q   <= '0;
      cnt_q    <= '0;
      timer_q  <= '0;
      id_q     <= '0;
      valid_q  <= 1'b0;
      change_q <= 1'b0;
      lost_q   <= 1'b0;
      period_q <= '0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      id_q     <= id_d;
      valid_q  <= valid_d;
      change_q <= change_d;
      lost_q   <= lost_d;
      period_q <= period_d;
    end
  end

  // Next-state: vote, lock/switch and timeout handling.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    id_d     = id_q;
    valid_d  = valid_q;
    change_d = 1'b0;
    lost_d   = 1'b0;
    period_d = valid_c ? clk_count : period_q;

    if (valid_c) begin
      timer_d = '0;
    end else if (timer_q == TIMEOUT) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + TIMER_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (valid_c) begin
          cand_d  = decision;
          cnt_d   = CNT_W'(1);
          state_d = S_CAND;
        end
      end

      S_CAND: begin
        if (valid_c) begin
          if (decision == cand_q) begin
            if (cnt_inc_c == CONFIRM) begin
              state_d  = S_LOCKED;
              id_d     = cand_q;
              valid_d  = 1'b1;
              change_d = 1'b1;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_inc_c;
            end
          end else begin
            cand_d = decision;
            cnt_d  = CNT_W'(1);
          end
        end else if (done || timeout_c) begin
          // An invalid result or a stale vote abandons the candidate.
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end

      S_LOCKED: begin
        if (valid_c) begin
          if (decision == id_q) begin
            cnt_d = '0;
          end else if ((decision == cand_q) && (cnt_q != '0)) begin
            if (cnt_inc_c == CONFIRM) begin
              id_d     = cand_q;
              change_d = 1'b1;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_inc_c;
            end
          end else begin
            cand_d = decision;
            cnt_d  = CNT_W'(1);
          end
        end else if (timeout_c) begin
          state_d = S_IDLE;
          id_d    = '0;
          valid_d = 1'b0;
          lost_d  = 1'b1;
          cnt_d   = '0;
        end else if (done) begin
          cnt_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign beacon_id     = id_q;
  assign beacon_valid  = valid_q;
  assign beacon_change = change_q;
  assign beacon_lost   = lost_q;
  assign last_period   = period_q;

endmodule

// File: doc/ir_beacon_voter.md
# ir_beacon_voter

Downstream consumer of the IR frequency detector. It accepts the detector's per-measurement `decision` code, qualified by a one-cycle `done` strobe, and votes across consecutive measurements. It publishes a stable beacon identity only after `CONFIRM_N` agreeing results. It drops the lock when no valid measurement arrives within a timeout window. The navigation/steering logic reads its outputs instead of raw, glitch-prone detector decisions.

## Interface
- `CONFIRM_N`, 4: consecutive identical valid decisions required to lock or to switch beacon; legal range 2..15.
- `TIMEOUT_CYCLES`, 1_500_000: clk cycles (15 ms at 100 MHz) without a valid decision before lock is lost; must be < 2^21.
- `clk` in 1: system clock, 100 MHz, rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `done` in 1: one-cycle strobe from the detector; `decision` is sampled only when `done` is high.
- `decision` in 3: detector result. 1..4 are beacon codes. 0 and 5..7 are "no valid frequency".
- `clk_count` in 20: detector's measured period in clk cycles; not used for voting, captured on each valid `done`.
- `beacon_id` out 3: locked beacon code, 0 when unlocked.
- `beacon_valid` out 1: high while locked.
- `beacon_change` out 1: one-cycle pulse on lock acquisition or beacon switch.
- `beacon_lost` out 1: one-cycle pulse when the lock times out.
- `last_period` out 20: `clk_count` captured at the last valid `done`.

## Operation
- States: IDLE, CAND, LOCKED.
- Registers:
  - `cand[2:0]`: candidate code.
  - `cnt[3:0]`: agreement count.
  - `timer[20:0]`: cycles since the last valid decision; saturates at `TIMEOUT_CYCLES`.
- Valid `done`: `done`=1 and `decision` in 1..4. It clears `timer` and loads `last_period`.
- Invalid `done`: `done`=1 with any other code.
  - Does not clear `timer`.
  - In CAND, forces IDLE with `cnt`=0.
  - In LOCKED, clears `cnt` only, discarding the challenger.
- IDLE, on valid `done`: `cand`=decision, `cnt`=1, go to CAND.
- CAND, on valid `done`:
  - If decision==`cand` and `cnt`+1==`CONFIRM_N`: go to LOCKED, `beacon_id`=`cand`, `beacon_valid`=1, pulse `beacon_change`, `cnt`=0.
  - Else if decision==`cand`: `cnt`++.
  - Else: `cand`=decision, `cnt`=1.
- LOCKED, on valid `done`:
  - If decision==`beacon_id`: `cnt`=0 and the challenger is discarded.
  - Else if decision==`cand` and `cnt`>0: `cnt`++. If `cnt` reaches `CONFIRM_N`, set `beacon_id`=`cand`, pulse `beacon_change`, `cnt`=0. `beacon_valid` stays 1.
  - Else: `cand`=decision, `cnt`=1.
- Timeout: `timer`==`TIMEOUT_CYCLES`.
  - In LOCKED: go to IDLE, `beacon_id`=0, `beacon_valid`=0, pulse `beacon_lost`, `cnt`=0.
  - In CAND: go to IDLE silently.
  - In IDLE: no effect.
- `timer` keeps running in all states; the timeout check acts on the state as described above.
- A valid `done` in the same cycle the timer would reach `TIMEOUT_CYCLES` takes priority. The timer clears and no timeout occurs.
- `beacon_change` and `beacon_lost` are never high in the same cycle.

## Timing
- Reset state (asynchronous, while `rst_n`=0):
  - State IDLE.
  - All outputs 0, including `last_period`=0.
  - `cand`=0, `cnt`=0, `timer`=0.
- All outputs are registered.
- Lock latency: `beacon_valid` and `beacon_change` assert on the clk edge that samples the `CONFIRM_N`-th agreeing `done`. They are visible one cycle after that `done`.
- `beacon_lost` asserts in the cycle `timer` hits `TIMEOUT_CYCLES`, i.e. `TIMEOUT_CYCLES` cycles after the last valid `done`.
- Back-to-back `done` on consecutive cycles must each be counted.
- Reset asserted mid-vote or while locked discards all history. After release, the next valid `done` starts a fresh count.

## Test plan
- Lock: apply 4 `done` pulses with decision=3, `clk_count`=14400, spaced 14400 cycles.
  - Required: after the 4th, `beacon_id`=3, `beacon_valid`=1, one `beacon_change` pulse, `last_period`=14400.
- Noisy vote: apply decisions 3,3,2,3,3,3,3.
  - Required: lock to 3 only after the 7th `done`; `beacon_change` pulses exactly once.
- Switch: while locked on 3, apply 2,2,2,3,2,2,2,2.
  - Required: the 3 discards the challenger; `beacon_id` becomes 2 after the final 2; `beacon_valid` never drops.
- Timeout: while locked, stop all `done` pulses.
  - Required: after exactly 1_500_000 cycles, `beacon_lost` pulses once; `beacon_id`=0, `beacon_valid`=0.
  - Also: invalid codes (0, 6) arriving every 10000 cycles do not prevent this timeout.
- Boundary: deliver a valid matching `done` exactly on the cycle the timer would expire.
  - Required: no `beacon_lost`; lock retained.
- Reset: assert `rst_n`=0 asynchronously mid-CAND and while LOCKED.
  - Required: outputs go to 0 immediately without waiting for a clk edge; after release, a relock needs 4 fresh agreeing decisions.
